bcd_counter: RTL and testbench
==============================

// Module: bcd_counter
// PURPOSE
//   Three-digit decimal (BCD) event counter, range 000..999.
//   Each clock cycle in which Cin is high increments the count by one.
//   Cout flags the 999 -> 000 rollover, so several counters can be cascaded
//   into wider decimal counters or drive a display/timer chain.
//   Leaf block: no bus interface, single clock domain.
// PARAMETERS
//   DIGITS  3  number of cascaded BCD digits; q width = 4*DIGITS (default 12)
// PORTS
//   Clk    in   1   system clock, all state updates on rising edge
//   Rst_n  in   1   reset, asynchronous, ACTIVE-HIGH (1 = reset) despite the _n name
//   Cin    in   1   count enable / carry-in; one increment per cycle while high
//   Cout   out  1   carry-out; high when Cin=1 and q=999 (combinational)
//   q      out  12  BCD count; q[3:0]=units, q[7:4]=tens, q[11:8]=hundreds
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high.
//   Reset: Rst_n=1 forces q=12'h000 immediately, without waiting for Clk.
//     Cout=0 while in reset. Reset dominates Cin.
//     First increment occurs on the first rising Clk edge after Rst_n falls
//     with Cin=1.
//   Counting, on each rising Clk edge with Rst_n=0:
//     Cin=0: q holds.
//     Cin=1: units += 1.
//       Units 9 -> 0 generates carry into tens.
//       Tens 9 -> 0 (when carried into) generates carry into hundreds.
//       Hundreds 9 -> 0 (when carried into) wraps the whole counter to 000.
//   Per-digit carry: c_out[i] = c_in[i] & (digit[i]==4'd9); c_in[0] = Cin.
//   Cout = c_out[DIGITS-1], i.e. Cin & (q==12'h999).
//     Purely combinational, asserted in the same cycle as the edge that wraps.
//   Latency: q reflects an increment one cycle after Cin is sampled high.
//   Digit encoding: only values 0..9 are ever produced.
//     Illegal codes A..F (unreachable after reset) step to 0 on the next
//     enabled increment of that digit without generating a carry.
//   Continuous Cin=1: counts 1 per cycle; 1000 cycles returns q to its start
//     value with exactly one Cout pulse.
//   Reset mid-count clears q at once; counting resumes from 000.
// STRUCTURE
//   Sub-module bcd_digit (Clk, Rst_n, c_in, c_out, d[3:0]):
//     one mod-10 digit with carry chain.
//     Instantiate DIGITS times with a generate loop; ripple c_out -> next c_in.
//   Shared package: localparam BCD_MAX = 4'd9, digit width 4;
//     no typedefs needed.
//   No FSM; state is the DIGITS x 4-bit registers only.
// TESTING
//   1. Rst_n=1 for 100 cycles, Cin=0 -> q=000, Cout=0.
//      Assert Rst_n asynchronously mid-cycle -> q clears before the next edge.
//   2. Release reset, Cin=0 for 20 cycles -> q stays 000.
//      Then 30 single-cycle Cin pulses spaced 5 cycles apart -> q=12'h030,
//      stepping 001,002,...; q never changes on Cin=0 cycles.
//   3. From 009, Cin pulse -> q=010.
//      From 099, Cin pulse -> q=100.
//      Cout=0 in both cases.
//   4. Count to 999, hold Cin=1 -> Cout=1 during that cycle.
//      Next edge q=000; Cout returns to 0.
//   5. Cin held high 1000 cycles from 000 -> q=000 again,
//      exactly one Cout pulse; every digit stays in 0..9 throughout.
//   6. Assert Rst_n while Cin=1 at q=537 -> q=000 immediately.
//      Release -> next enabled edge q=001.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared constants for the decimal counter slice.
// Holds the digit width, the largest legal BCD code and the digit-step helper.
package bcd_counter_pkg;

    localparam int          DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    // One enabled step of a single decimal digit.
    // Codes at or above 9 (including the illegal A..F) land on 0, so a
    // corrupted digit heals on its next enabled increment.
    function automatic logic [DIGIT_W-1:0] bcd_step(
        input logic [DIGIT_W-1:0] d
    );
        if (d >= BCD_MAX) begin
            return '0;
        end
        return d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_counter_digit.sv
// bcd_digit: one mod-10 counter digit with ripple carry.
// Ports: Clk, Rst_n (async, active-high), c_in, c_out, d[3:0].
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               c_in,
    output logic               c_out,
    output logic [DIGIT_W-1:0] d
);

    logic [DIGIT_W-1:0] d_q;
    logic [DIGIT_W-1:0] d_d;

    always_comb begin
        d_d = d_q;
        if (c_in) begin
            d_d = bcd_step(d_q);
        end
    end

    always_ff @(posedge Clk or posedge Rst_n) begin
        if (Rst_n) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

    // Only a true 9 propagates a carry; illegal codes wrap silently.
    assign c_out = c_in & (d_q == BCD_MAX);
    assign d     = d_q;

endmodule

// File: rtl/bcd_counter.sv
// bcd_counter: DIGITS-digit decimal event counter with carry-out.
// Ports: Clk, Rst_n (async, active-high), Cin, Cout (comb), q[4*DIGITS-1:0].
module bcd_counter
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      Cin,
    output logic                      Cout,
    output logic [DIGIT_W*DIGITS-1:0] q
);

    // carry[i] enters digit i; carry[DIGITS] leaves the top digit.
    logic [DIGITS:0] carry;

    assign carry[0] = Cin;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .Clk   (Clk),
            .Rst_n (Rst_n),
            .c_in  (carry[i]),
            .c_out (carry[i+1]),
            .d     (q[DIGIT_W*i +: DIGIT_W])
        );
    end

    assign Cout = carry[DIGITS];

endmodule

// File: tb/tb_bcd_counter.sv
// Bench for bcd_counter: vector table, directed corners and a random run
// compared against an integer event-count model.
module tb_bcd_counter;

    logic        clk;
    logic        rst;
    logic        cin;
    logic        cout;
    logic [11:0] q;

    int n_cmp;
    int n_bad;
    int cnt;

    bcd_counter #(.DIGITS(3)) dut (
        .Clk   (clk),
        .Rst_n (rst),
        .Cin   (cin),
        .Cout  (cout),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cin;
        logic [11:0] q;
        logic        cout;
    } vec_t;

    vec_t vt[12];

    function automatic logic [11:0] to_bcd(input int n);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        h = 4'(n / 100);
        t = 4'((n / 10) % 10);
        u = 4'(n % 10);
        return {h, t, u};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_digits();
        logic ok;
        ok = (q[3:0] <= 4'd9) && (q[7:4] <= 4'd9) && (q[11:8] <= 4'd9);
        chk("digit_legal", {31'd0, ok}, 32'd1);
    endtask

    // One cycle: drive after negedge, check Cout before the edge,
    // then check q just after the edge against the model.
    task automatic step(input logic r, input logic c);
        @(negedge clk);
        rst = r;
        cin = c;
        if (r) cnt = 0;
        #1;
        chk("cout", {31'd0, cout},
            {31'd0, (c && !r && cnt == 999)});
        @(posedge clk);
        #1;
        if (!r && c) cnt = (cnt + 1) % 1000;
        chk("q", {20'd0, q}, {20'd0, to_bcd(cnt)});
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic count_to(input int target);
        while (cnt != target) step(1'b0, 1'b1);
    endtask

    // Assert reset between edges and verify q clears without a clock edge.
    task automatic async_reset_check(input logic c);
        @(negedge clk);
        cin = c;
        #2;
        rst = 1'b1;
        cnt = 0;
        #1;
        chk("async_q", {20'd0, q}, 32'd0);
        chk("async_cout", {31'd0, cout}, 32'd0);
        chk("async_no_edge", {31'd0, clk}, 32'd0);
    endtask

    initial begin
        int pulses;
        n_cmp = 0;
        n_bad = 0;
        cnt   = 0;
        rst   = 1'b1;
        cin   = 1'b0;

        // Long reset with Cin low.
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            chk("rst_q", {20'd0, q}, 32'd0);
            chk("rst_cout", {31'd0, cout}, 32'd0);
        end

        // Vector table: reset dominance, holding, counting.
        vt[0]  = '{1'b1, 1'b1, 12'h000, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 12'h000, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 12'h001, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 12'h002, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 12'h002, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 12'h003, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 12'h000, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 12'h001, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 12'h001, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 12'h002, 1'b0};
        vt[10] = '{1'b0, 1'b1, 12'h003, 1'b0};
        vt[11] = '{1'b0, 1'b1, 12'h004, 1'b0};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst = vt[i].rst;
            cin = vt[i].cin;
            #1;
            chk("vec_cout", {31'd0, cout}, {31'd0, vt[i].cout});
            @(posedge clk);
            #1;
            chk("vec_q", {20'd0, q}, {20'd0, vt[i].q});
        end
        cnt = 4;

        // Mid-cycle asynchronous reset.
        async_reset_check(1'b0);
        do_reset();

        // Idle then spaced single pulses.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        for (int p = 0; p < 30; p++) begin
            step(1'b0, 1'b1);
            for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        end
        chk("pulses_q", {20'd0, q}, 32'h030);

        // Digit carries.
        do_reset();
        count_to(9);
        step(1'b0, 1'b1);
        chk("carry_010", {20'd0, q}, 32'h010);
        count_to(99);
        step(1'b0, 1'b1);
        chk("carry_100", {20'd0, q}, 32'h100);

        // 999 rollover.
        count_to(999);
        @(negedge clk);
        cin = 1'b1;
        #1;
        chk("cout_999", {31'd0, cout}, 32'd1);
        @(posedge clk);
        #1;
        cnt = 0;
        chk("wrap_q", {20'd0, q}, 32'h000);
        chk("cout_after", {31'd0, cout}, 32'd0);

        // 1000 continuous increments from 000.
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            cin = 1'b1;
            #1;
            if (cout) pulses++;
            @(posedge clk);
            #1;
            cnt = (cnt + 1) % 1000;
            chk("run_q", {20'd0, q}, {20'd0, to_bcd(cnt)});
            chk_digits();
        end
        chk("run_end", {20'd0, q}, 32'h000);
        chk("run_pulses", pulses, 32'd1);

        // Reset while enabled at 537.
        count_to(537);
        async_reset_check(1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("resume_001", {20'd0, q}, 32'h001);

        // Random run against the event-count model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 511) == 0), ($urandom_range(0, 3) != 0));
            chk_digits();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
